// File: rtl/reg_bank_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_window_ctrl_if
// Description : Bundle between decode/writeback and the bank window
//               controller.
//               Core-side controls : call_req, ret_req, clear_flags.
//               CPU writeback      : cpu_write_addr/data/en (en is active-low).
//               Register file side : bank_select, rf_write_addr/data/en.
//               Status             : busy, overflow, underflow.
//               master = core/testbench side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_window_ctrl_if #(
    parameter int BANK_W = 8
);
    logic              call_req;
    logic              ret_req;
    logic              clear_flags;
    logic [3:0]        cpu_write_addr;
    logic [15:0]       cpu_write_data;
    logic              cpu_write_en;
    logic [BANK_W-1:0] bank_select;
    logic [3:0]        rf_write_addr;
    logic [15:0]       rf_write_data;
    logic              rf_write_en;
    logic              busy;
    logic              overflow;
    logic              underflow;

    modport master (
        output call_req, ret_req, clear_flags,
               cpu_write_addr, cpu_write_data, cpu_write_en,
        input  bank_select, rf_write_addr, rf_write_data, rf_write_en,
               busy, overflow, underflow
    );

    modport slave (
        input  call_req, ret_req, clear_flags,
               cpu_write_addr, cpu_write_data, cpu_write_en,
        output bank_select, rf_write_addr, rf_write_data, rf_write_en,
               busy, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_window_ctrl
// Description : Owns bank_select for the banked register file and sequences
//               call/return windowing. CALL advances to the next bank and
//               zeroes its GPRs through the register file write port; RET
//               steps back one bank. CPU writeback is passed through while
//               idle and overridden by clear writes while busy.
// Ports       : clock   - system clock, rising edge
//               reset_n - asynchronous reset, active-low
//               bus     - reg_bank_window_ctrl_if.slave (controls, CPU
//                         writeback, register file write port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_window_ctrl #(
    parameter int BANK_W        = 8,
    parameter int REGS_PER_BANK = 8,
    parameter int CLEAR_ON_CALL = 1
) (
    input  wire logic            clock,
    input  wire logic            reset_n,
    reg_bank_window_ctrl_if.slave bus
);

    localparam logic [BANK_W-1:0] TOP_BANK = {BANK_W{1'b1}};
    localparam logic [BANK_W-1:0] BOT_BANK = '0;
    localparam logic [3:0]        LAST_IDX = 4'(REGS_PER_BANK - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [BANK_W-1:0] bank_q,      bank_d;
    logic [3:0]        clr_cnt_q,   clr_cnt_d;
    logic              busy_q,      busy_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    // Opposing requests in the same cycle cancel out entirely.
    logic w_call_only;
    logic w_ret_only;
    assign w_call_only = bus.call_req & ~bus.ret_req;
    assign w_ret_only  = bus.ret_req  & ~bus.call_req;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        clr_cnt_d   = clr_cnt_q;
        busy_d      = busy_q;
        // clear_flags drops both flags; a new error below re-sets its flag,
        // so a simultaneous set wins over the clear.
        overflow_d  = overflow_q  & ~bus.clear_flags;
        underflow_d = underflow_q & ~bus.clear_flags;

        case (state_q)
            ST_IDLE: begin
                if (w_call_only) begin
                    // Bounds are checked before the increment so the bank
                    // never wraps.
                    if (bank_q == TOP_BANK) begin
                        overflow_d = 1'b1;
                    end else begin
                        bank_d = bank_q + BANK_W'(1);
                        if (CLEAR_ON_CALL != 0) begin
                            state_d   = ST_CLEAR;
                            clr_cnt_d = 4'd0;
                            busy_d    = 1'b1;
                        end
                    end
                end else if (w_ret_only) begin
                    if (bank_q == BOT_BANK) begin
                        underflow_d = 1'b1;
                    end else begin
                        bank_d = bank_q - BANK_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                // Requests are ignored here; the core is stalled by busy.
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = 4'd0;
                    busy_d    = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = 4'd0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bank_q      <= '0;
            clr_cnt_q   <= 4'd0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            clr_cnt_q   <= clr_cnt_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Write-port mux: zero-latency CPU pass-through while idle, clear writes
    // into the (already switched) new bank while clearing. Reset forces
    // ST_IDLE, so an interrupted clear issues no further writes.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            bus.rf_write_addr = clr_cnt_q;
            bus.rf_write_data = 16'h0000;
            bus.rf_write_en   = 1'b0;
        end else begin
            bus.rf_write_addr = bus.cpu_write_addr;
            bus.rf_write_data = bus.cpu_write_data;
            bus.rf_write_en   = bus.cpu_write_en;
        end
    end

    assign bus.bank_select = bank_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_window_ctrl
// Description : Randomized scoreboard bench for reg_bank_window_ctrl. A
//               behavioural window model predicts the outputs of each cycle;
//               a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_window_ctrl;

    localparam int TOP  = 255;
    localparam int NREG = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    reg_bank_window_ctrl_if #(.BANK_W(8)) bus ();

    reg_bank_window_ctrl #(
        .BANK_W        (8),
        .REGS_PER_BANK (NREG),
        .CLEAR_ON_CALL (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  bank;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        en;
        logic        busy;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: window depth, remaining clear writes, sticky flags.
    int m_bank;
    int m_clr_left;
    int m_clr_idx;
    bit m_ovf;
    bit m_unf;

    task automatic model_reset();
        m_bank = 0; m_clr_left = 0; m_clr_idx = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit c, input bit r, input bit cf);
        bit set_o = 0;
        bit set_u = 0;
        if (m_clr_left > 0) begin
            m_clr_idx++;
            m_clr_left--;
        end else if (c && !r) begin
            if (m_bank == TOP) set_o = 1;
            else begin
                m_bank++;
                m_clr_left = NREG;
                m_clr_idx  = 0;
            end
        end else if (r && !c) begin
            if (m_bank == 0) set_u = 1;
            else m_bank--;
        end
        if (cf) begin m_ovf = 0; m_unf = 0; end
        if (set_o) m_ovf = 1;
        if (set_u) m_unf = 1;
    endtask

    // Drive one cycle of stimulus (at posedge+1), publish the expectation,
    // then advance the model across the next rising edge.
    task automatic do_cycle(input bit c, input bit r, input bit cf,
                            input logic [3:0] a, input logic [15:0] d,
                            input logic en);
        exp_t e;
        bus.call_req       = c;
        bus.ret_req        = r;
        bus.clear_flags    = cf;
        bus.cpu_write_addr = a;
        bus.cpu_write_data = d;
        bus.cpu_write_en   = en;
        e.bank = 8'(m_bank);
        e.ovf  = m_ovf;
        e.unf  = m_unf;
        if (m_clr_left > 0) begin
            e.addr = 4'(m_clr_idx); e.data = 16'h0000; e.en = 1'b0; e.busy = 1'b1;
        end else begin
            e.addr = a; e.data = d; e.en = en; e.busy = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clock);
        if (reset_n) model_step(c, r, cf);
        #1;
    endtask

    task automatic idle_cycle();
        do_cycle(0, 0, 0, 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
    endtask

    task automatic rand_cycle();
        int  p = $urandom_range(0, 99);
        bit  c = (p < 15) || (p >= 95);
        bit  r = (p >= 15 && p < 30) || (p >= 95);
        bit  cf = ($urandom_range(0, 9) == 0);
        do_cycle(c, r, cf, 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
    endtask

    task automatic drain_clear();
        while (m_clr_left > 0) idle_cycle();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("bank_select",   16'(bus.bank_select),   16'(e.bank));
            chk("rf_write_addr", 16'(bus.rf_write_addr), 16'(e.addr));
            chk("rf_write_data", bus.rf_write_data,      e.data);
            chk("rf_write_en",   16'(bus.rf_write_en),   16'(e.en));
            chk("busy",          16'(bus.busy),          16'(e.busy));
            chk("overflow",      16'(bus.overflow),      16'(e.ovf));
            chk("underflow",     16'(bus.underflow),     16'(e.unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        bus.call_req = 0; bus.ret_req = 0; bus.clear_flags = 0;
        bus.cpu_write_addr = 0; bus.cpu_write_data = 0; bus.cpu_write_en = 1;
        @(posedge clock); #1;

        // Reset held: reset values with the core idle.
        do_cycle(0, 0, 0, 4'h0, 16'h0000, 1'b1);
        do_cycle(1, 0, 0, 4'h0, 16'h0000, 1'b1);
        reset_n = 1'b1;

        // Pass-through of a CPU write in IDLE.
        do_cycle(0, 0, 0, 4'h3, 16'hBEEF, 1'b0);

        // CALL at bank 0 followed by the full clear sequence.
        do_cycle(1, 0, 0, 4'h1, 16'h1234, 1'b1);
        drain_clear();
        idle_cycle();

        // Back to 0, then RET at bank 0 raises underflow; clear it.
        do_cycle(0, 1, 0, 4'h2, 16'h0001, 1'b1);
        do_cycle(0, 1, 0, 4'h2, 16'h0002, 1'b1);
        idle_cycle();
        do_cycle(0, 0, 1, 4'h2, 16'h0003, 1'b1);

        // Climb to the top bank.
        while (m_bank != TOP) begin
            do_cycle(1, 0, 0, 4'($urandom_range(0, 15)), 16'($urandom), 1'b1);
            drain_clear();
        end
        // CALL at top: overflow, no clear; set beats simultaneous clear_flags.
        do_cycle(1, 0, 0, 4'h9, 16'hAAAA, 1'b1);
        idle_cycle();
        do_cycle(1, 0, 1, 4'h9, 16'hAAAA, 1'b1);
        idle_cycle();
        do_cycle(0, 0, 1, 4'h9, 16'hAAAA, 1'b1);
        idle_cycle();

        // Walk down to bank 5 and issue CALL+RET together.
        while (m_bank != 5) do_cycle(0, 1, 0, 4'hC, 16'h5555, 1'b1);
        do_cycle(1, 1, 0, 4'hA, 16'hCAFE, 1'b0);
        idle_cycle();
        idle_cycle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) rand_cycle();

        // Reset in the middle of a clear (clear index 3 in flight).
        drain_clear();
        if (m_bank == TOP) do_cycle(0, 1, 0, 4'h0, 16'h0, 1'b1);
        do_cycle(1, 0, 0, 4'h0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 4'h0, 16'h0, 1'b1);
        begin
            exp_t e;
            e.bank = 8'(m_bank); e.addr = 4'(m_clr_idx); e.data = 16'h0;
            e.en = 1'b0; e.busy = 1'b1; e.ovf = m_ovf; e.unf = m_unf;
            exp_q.push_back(e);
            @(negedge clock); #1;
            reset_n = 1'b0;
            model_reset();
            @(posedge clock); #1;
        end
        do_cycle(0, 0, 0, 4'h4, 16'h0, 1'b1);
        do_cycle(0, 0, 0, 4'h5, 16'h0, 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 4'($urandom_range(0, 15)), 16'($urandom), 1'b1);
        for (int i = 0; i < 200; i++) rand_cycle();

        @(negedge clock); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
